// File: rtl/rv64_fetch_decode_exec.sv
// rtl/rv64_fetch_decode_exec.sv - RV64I PC register, instruction decoder and ALU/branch unit
// Only the PC is registered; every other output follows instr/src1/src2/pc combinationally.
module rv64_fetch_decode_exec #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [63:0] imm,
  output logic [63:0] result,
  output logic        reg_wr,
  output logic        mem_to_reg,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mem_op,
  output logic [63:0] data_wr,
  output logic        is_csr,
  output logic        ecall,
  output logic        mret,
  output logic [11:0] csr_addr,
  output logic        error,
  output logic        done
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_REG32  = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

  logic [63:0] pc_q, pc_d, next_pc, pc_plus4;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [63:0] alu_b, alu_res, alu_sra;
  logic [31:0] aluw_res, aluw_sra;
  logic        is_reg, is_sub, is_sra, taken;
  logic        illegal, wr, ld, st, csr, ec, mr, brk;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign csr_addr = instr[31:20];
  assign mem_op   = funct3;
  assign data_wr  = src2;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 64'd4;

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'h000};
  assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // instr[30] selects sub/sra in both register and immediate forms; addi never subtracts
  assign is_reg   = (opcode == OPC_REG) || (opcode == OPC_REG32);
  assign alu_b    = is_reg ? src2 : imm_i;
  assign is_sub   = is_reg && instr[30] && (funct3 == 3'b000);
  assign is_sra   = instr[30];
  assign alu_sra  = $signed(src1) >>> alu_b[5:0];
  assign aluw_sra = $signed(src1[31:0]) >>> alu_b[4:0];

  always_comb begin
    alu_res = 64'd0;
    case (funct3)
      3'b000: alu_res = is_sub ? src1 - alu_b : src1 + alu_b;
      3'b001: alu_res = src1 << alu_b[5:0];
      3'b010: alu_res = {63'd0, $signed(src1) < $signed(alu_b)};
      3'b011: alu_res = {63'd0, src1 < alu_b};
      3'b100: alu_res = src1 ^ alu_b;
      3'b101: alu_res = is_sra ? alu_sra : src1 >> alu_b[5:0];
      3'b110: alu_res = src1 | alu_b;
      3'b111: alu_res = src1 & alu_b;
    endcase
  end

  always_comb begin
    aluw_res = 32'd0;
    case (funct3)
      3'b000:  aluw_res = is_sub ? src1[31:0] - alu_b[31:0] : src1[31:0] + alu_b[31:0];
      3'b001:  aluw_res = src1[31:0] << alu_b[4:0];
      3'b101:  aluw_res = is_sra ? aluw_sra : src1[31:0] >> alu_b[4:0];
      default: aluw_res = 32'd0;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = src1 == src2;
      3'b001:  taken = src1 != src2;
      3'b100:  taken = $signed(src1) < $signed(src2);
      3'b101:  taken = $signed(src1) >= $signed(src2);
      3'b110:  taken = src1 < src2;
      3'b111:  taken = src1 >= src2;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    wr      = 1'b0;
    ld      = 1'b0;
    st      = 1'b0;
    csr     = 1'b0;
    ec      = 1'b0;
    mr      = 1'b0;
    brk     = 1'b0;
    imm     = 64'd0;
    result  = 64'd0;
    next_pc = pc_plus4;
    case (opcode)
      OPC_LUI:   begin imm = imm_u; result = imm_u; wr = 1'b1; end
      OPC_AUIPC: begin imm = imm_u; result = pc_q + imm_u; wr = 1'b1; end
      OPC_JAL:   begin imm = imm_j; result = pc_plus4; next_pc = pc_q + imm_j; wr = 1'b1; end
      OPC_JALR: begin
        imm     = imm_i;
        result  = pc_plus4;
        next_pc = (src1 + imm_i) & ~64'd1;
        wr      = 1'b1;
        illegal = funct3 != 3'b000;
      end
      OPC_BRANCH: begin
        imm     = imm_b;
        illegal = funct3[2:1] == 2'b01;
        if (taken) next_pc = pc_q + imm_b;
      end
      OPC_LOAD:  begin imm = imm_i; result = src1 + imm_i; wr = 1'b1; ld = 1'b1; illegal = funct3 == 3'b111; end
      OPC_STORE: begin imm = imm_s; result = src1 + imm_s; st = 1'b1; illegal = funct3[2]; end
      OPC_IMM: begin
        imm    = imm_i;
        result = alu_res;
        wr     = 1'b1;
        if (funct3 == 3'b001) illegal = instr[31:26] != 6'b000000;
        else if (funct3 == 3'b101) illegal = (instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000);
      end
      OPC_REG: begin
        result  = alu_res;
        wr      = 1'b1;
        illegal = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_IMM32: begin
        imm    = imm_i;
        result = {{32{aluw_res[31]}}, aluw_res};
        wr     = 1'b1;
        case (funct3)
          3'b000:  illegal = 1'b0;
          3'b001:  illegal = funct7 != 7'b0000000;
          3'b101:  illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          default: illegal = 1'b1;
        endcase
      end
      OPC_REG32: begin
        result  = {{32{aluw_res[31]}}, aluw_res};
        wr      = 1'b1;
        illegal = !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101)) ||
                  !((funct7 == 7'b0000000) || ((funct7 == 7'b0100000) && (funct3 != 3'b001)));
      end
      OPC_SYSTEM: begin
        imm = imm_i;
        if (instr == INSN_ECALL) ec = 1'b1;
        else if (instr == INSN_EBREAK) brk = 1'b1;
        else if (instr == INSN_MRET) mr = 1'b1;
        else if ((funct3 == 3'b000) || (funct3 == 3'b100)) illegal = 1'b1;
        else begin csr = 1'b1; wr = 1'b1; end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign error      = illegal && !rst;
  assign reg_wr     = wr && !error;
  assign mem_rd     = ld && !error;
  assign mem_wr     = st && !error;
  assign is_csr     = csr && !error;
  assign ecall      = ec && !error;
  assign mret       = mr && !error;
  assign done       = brk && !error;
  assign mem_to_reg = ld;

  // A CSR redirect must escape a halted (error/ebreak) core, so it outranks the hold
  always_comb begin
    pc_d = next_pc;
    if (redirect_en) pc_d = redirect_pc;
    else if (error || done) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end
endmodule

// File: tb/tb_rv64_fetch_decode_exec.sv
// tb/tb_rv64_fetch_decode_exec.sv - scoreboard bench for rv64_fetch_decode_exec
// Directed cases, then random instructions checked against a behavioural RV64I model.
module tb_rv64_fetch_decode_exec;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [63:0] src1, src2, redirect_pc;
  logic        redirect_en;
  logic [63:0] pc, imm, result, data_wr;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_wr, mem_to_reg, mem_rd, mem_wr, is_csr, ecall, mret, error, done;
  logic [2:0]  mem_op;
  logic [11:0] csr_addr;

  rv64_fetch_decode_exec #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .instr(instr), .src1(src1), .src2(src2),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .pc(pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .result(result),
    .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_op(mem_op), .data_wr(data_wr), .is_csr(is_csr), .ecall(ecall), .mret(mret),
    .csr_addr(csr_addr), .error(error), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in;
    logic [63:0] s2, pc, imm, result, npc;
    logic        chk_res;
    logic        reg_wr, mem_rd, mem_wr, mem_to_reg, is_csr, ecall, mret, error, done;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_pc;
  logic [6:0]  ops [0:11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h73};

  task automatic chk(input string n, input logic [31:0] ins, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s instr=%h: got %h want %h", n, ins, act, exp);
    end
  endtask

  function automatic logic [63:0] alu64(logic [2:0] f3, logic [63:0] x, logic [63:0] y, logic sub, logic sra);
    longint sx, sy, r;
    sx = x;
    sy = y;
    case (f3)
      3'd0: return sub ? x - y : x + y;
      3'd1: return x << y[5:0];
      3'd2: return (sx < sy) ? 64'd1 : 64'd0;
      3'd3: return (x < y) ? 64'd1 : 64'd0;
      3'd4: return x ^ y;
      3'd5: begin
        if (sra) begin r = sx >>> y[5:0]; return r; end
        return x >> y[5:0];
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [63:0] alu32(logic [2:0] f3, logic [63:0] x, logic [63:0] y, logic sub, logic sra);
    int          sx;
    logic [31:0] r;
    sx = x[31:0];
    case (f3)
      3'd0: r = sub ? x[31:0] - y[31:0] : x[31:0] + y[31:0];
      3'd1: r = x[31:0] << y[4:0];
      3'd5: if (sra) r = sx >>> y[4:0]; else r = x[31:0] >> y[4:0];
      default: r = 32'd0;
    endcase
    return longint'($signed(r));
  endfunction

  function automatic logic br_taken(logic [2:0] f3, logic [63:0] x, logic [63:0] y);
    longint sx, sy;
    sx = x;
    sy = y;
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return sx < sy;
      3'd5: return sx >= sy;
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] in, logic [63:0] a, logic [63:0] b, logic [63:0] cur_pc);
    exp_t        e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [63:0] ii, si, bi, ui, ji;
    logic        ill, w, ld, st, csr, ec, mr, brk;
    op = in[6:0];
    f3 = in[14:12];
    f7 = in[31:25];
    ii = longint'($signed(in[31:20]));
    si = longint'($signed({in[31:25], in[11:7]}));
    bi = longint'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
    ui = longint'($signed({in[31:12], 12'h000}));
    ji = longint'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
    e = '{default: '0};
    e.in = in; e.s2 = b; e.pc = cur_pc; e.npc = cur_pc + 64'd4; e.chk_res = 1'b1;
    {ill, w, ld, st, csr, ec, mr, brk} = 8'd0;
    case (op)
      7'h37: begin e.imm = ui; e.result = ui; w = 1'b1; end
      7'h17: begin e.imm = ui; e.result = cur_pc + ui; w = 1'b1; end
      7'h6f: begin e.imm = ji; e.result = cur_pc + 64'd4; e.npc = cur_pc + ji; w = 1'b1; end
      7'h67: begin e.imm = ii; e.result = cur_pc + 64'd4; e.npc = (a + ii) & ~64'd1; w = 1'b1; ill = f3 != 3'd0; end
      7'h63: begin
        e.imm = bi; e.chk_res = 1'b0; ill = (f3 == 3'd2) || (f3 == 3'd3);
        if (br_taken(f3, a, b)) e.npc = cur_pc + bi;
      end
      7'h03: begin e.imm = ii; e.result = a + ii; w = 1'b1; ld = 1'b1; ill = f3 == 3'd7; end
      7'h23: begin e.imm = si; e.result = a + si; st = 1'b1; ill = f3 > 3'd3; end
      7'h13: begin
        e.imm = ii; e.result = alu64(f3, a, ii, 1'b0, in[30]); w = 1'b1;
        ill = ((f3 == 3'd1) && (in[31:26] != 6'h00)) ||
              ((f3 == 3'd5) && !((in[31:26] == 6'h00) || (in[31:26] == 6'h10)));
      end
      7'h33: begin
        e.result = alu64(f3, a, b, f7 == 7'h20, f7 == 7'h20); w = 1'b1;
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      7'h1b: begin
        e.imm = ii; e.result = alu32(f3, a, ii, 1'b0, in[30]); w = 1'b1;
        ill = !((f3 == 3'd0) || ((f3 == 3'd1) && (f7 == 7'h00)) ||
                ((f3 == 3'd5) && ((f7 == 7'h00) || (f7 == 7'h20))));
      end
      7'h3b: begin
        e.result = alu32(f3, a, b, f7 == 7'h20, f7 == 7'h20); w = 1'b1;
        ill = !((((f3 == 3'd0) || (f3 == 3'd5)) && ((f7 == 7'h00) || (f7 == 7'h20))) ||
                ((f3 == 3'd1) && (f7 == 7'h00)));
      end
      7'h73: begin
        e.imm = ii; e.chk_res = 1'b0;
        if (in == ECALL) ec = 1'b1;
        else if (in == EBREAK) brk = 1'b1;
        else if (in == MRET) mr = 1'b1;
        else if ((f3 == 3'd0) || (f3 == 3'd4)) ill = 1'b1;
        else begin csr = 1'b1; w = 1'b1; e.chk_res = 1'b1; e.result = 64'd0; end
      end
      default: ill = 1'b1;
    endcase
    if (ill) e.chk_res = 1'b0;
    e.error = ill;
    e.reg_wr = w && !ill; e.mem_rd = ld && !ill; e.mem_wr = st && !ill;
    e.is_csr = csr && !ill; e.ecall = ec && !ill; e.mret = mr && !ill; e.done = brk && !ill;
    e.mem_to_reg = op == 7'h03;
    return e;
  endfunction

  task automatic issue(input logic [31:0] in, input logic [63:0] a, input logic [63:0] b,
                       input logic re, input logic [63:0] rpc);
    exp_t e;
    instr = in; src1 = a; src2 = b; redirect_en = re; redirect_pc = rpc;
    e = model(in, a, b, exp_pc);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (re) exp_pc = rpc;
    else if (!(e.error || e.done)) exp_pc = e.npc;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("pc", e.in, pc, e.pc);
        chk("rs1", e.in, rs1, e.in[19:15]);
        chk("rs2", e.in, rs2, e.in[24:20]);
        chk("rd", e.in, rd, e.in[11:7]);
        chk("csr_addr", e.in, csr_addr, e.in[31:20]);
        chk("mem_op", e.in, mem_op, e.in[14:12]);
        chk("data_wr", e.in, data_wr, e.s2);
        chk("imm", e.in, imm, e.imm);
        if (e.chk_res) chk("result", e.in, result, e.result);
        chk("error", e.in, error, e.error);
        chk("reg_wr", e.in, reg_wr, e.reg_wr);
        chk("mem_rd", e.in, mem_rd, e.mem_rd);
        chk("mem_wr", e.in, mem_wr, e.mem_wr);
        chk("mem_to_reg", e.in, mem_to_reg, e.mem_to_reg);
        chk("is_csr", e.in, is_csr, e.is_csr);
        chk("ecall", e.in, ecall, e.ecall);
        chk("mret", e.in, mret, e.mret);
        chk("done", e.in, done, e.done);
      end
    end
  end

  initial begin : driver
    logic [31:0] r;
    logic [63:0] a, b;
    int          k;
    rst = 1'b1; instr = 32'h0000_0013; src1 = '0; src2 = '0;
    redirect_en = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;
    chk("reset_pc", instr, pc, RESET_PC);
    instr = 32'h0000_0000;
    #1;
    chk("error_in_reset", instr, error, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = RESET_PC;

    issue(32'h0050_0093, 64'd0, 64'd0, 1'b0, 64'd0);
    issue(32'h0020_81bb, 64'h7fff_ffff, 64'd1, 1'b0, 64'd0);
    issue(32'h0020_8463, 64'd42, 64'd42, 1'b0, 64'd0);
    issue(32'h0020_8463, 64'd42, 64'd43, 1'b0, 64'd0);
    issue(32'h0041_00e7, 64'h8000_1003, 64'd0, 1'b0, 64'd0);
    issue(32'h0000_0000, 64'd0, 64'd0, 1'b0, 64'd0);
    issue(EBREAK, 64'd0, 64'd0, 1'b0, 64'd0);
    issue(32'h0050_0093, 64'd0, 64'd0, 1'b1, 64'h8000_0100);
    issue(32'h0000_0000, 64'd0, 64'd0, 1'b1, 64'h8000_0200);
    issue(32'h3420_2573, 64'd7, 64'd9, 1'b0, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      k = $urandom_range(0, 15);
      if (k < 12) r[6:0] = ops[k];
      else if (k == 12) begin
        case ($urandom_range(0, 2))
          0:       r = ECALL;
          1:       r = EBREAK;
          default: r = MRET;
        endcase
      end
      if (k < 12 && $urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 64'($urandom_range(0, 70)); b = 64'($urandom_range(0, 70)); end
        2: b = ~a;
        default: ;
      endcase
      issue(r, a, b, $urandom_range(0, 15) == 0, {$urandom, $urandom});
    end

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv64_fetch_decode_exec.md
Name: rv64_fetch_decode_exec

Overview:
- Single-cycle RV64I front half: PC register (fetch), combinational instruction decoder, and ALU/branch unit.
- Sits between instruction memory, the external register file / CSR unit, and the data-memory / write-back stage.
- Register-file reads, memory access and write-back mux live outside this block.

Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; the PC updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction at pc.
- src1  in  64  value of x[rs1]; the external block supplies 0 for x0.
- src2  in  64  value of x[rs2]; the external block supplies 0 for x0.
- redirect_en  in  1  trap/return redirect from the CSR unit.
- redirect_pc  in  64  redirect target.
- pc  out  64  current PC.
- rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- imm  out  64  sign-extended immediate (I/S/B/U/J per format; 0 for R-type).
- result  out  64  ALU result; also used as the memory address.
- reg_wr  out  1  write rd.
- mem_to_reg  out  1  rd takes load data instead of result.
- mem_rd, mem_wr  out  1 each  load / store strobe.
- mem_op  out  3  funct3 of load/store.
- data_wr  out  64  store data, equal to src2.
- is_csr, ecall, mret  out  1 each  SYSTEM decode flags.
- csr_addr  out  12  instr[31:20].
- error  out  1  illegal instruction.
- done  out  1  ebreak.

Behaviour:
- PC register
  - rst=1 at a rising edge: pc <= RESET_PC.
  - Otherwise the priority for the next pc is:
    - redirect_en: pc <= redirect_pc;
    - error or done: pc holds;
    - else pc <= computed next_pc.
- All other outputs are combinational from instr/src1/src2/pc.
- error is forced to 0 while rst=1.
- Decoded opcodes:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32.
  - SYSTEM: ecall 0x00000073, ebreak 0x00100073, mret 0x30200073, CSRRW/S/C and their immediate forms.
- result per instruction:
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL/JALR: pc+4.
  - LOAD/STORE: src1+imm.
  - OP/OP-IMM: add, sub, sll, slt, sltu, xor, srl, sra, or, and. Shift amount is operand[5:0]; slt/sltu give 0/1.
  - W variants (addw, subw, sllw, srlw, sraw, addiw, slliw, srliw, sraiw):
    - compute on the low 32 bits with shift amount [4:0];
    - sign-extend bit 31 of the result to 64 bits;
    - srlw/sraw shift the low word only.
- next_pc:
  - Default: pc+4.
  - JAL: pc+imm.
  - JALR: (src1+imm) & ~1.
  - BRANCH (beq, bne, blt, bge, bltu, bgeu): pc+imm when taken, pc+4 otherwise.
  - All arithmetic is modulo 2^64.
- Control outputs:
  - reg_wr=1: LUI, AUIPC, JAL, JALR, LOAD, OP*, CSR.
  - reg_wr=0: BRANCH, STORE, ecall, ebreak, mret.
  - mem_to_reg=1 for LOAD only.
  - mem_op = funct3.
- CSR instructions: is_csr=1, reg_wr=1, result=0. The external block substitutes the CSR read data for rd.
- Illegal instruction (error=1):
  - unknown opcode;
  - funct7 other than 0000000, or 0100000 for sub/sra/subw/sraw;
  - slli/srli/srai with instr[31:26] not 000000/010000 (srai only);
  - W-shift with bad funct7;
  - load funct3=111;
  - store funct3>011;
  - branch funct3 010/011;
  - JALR funct3≠0;
  - SYSTEM funct3=100;
  - any other SYSTEM encoding.
- Error suppression: error=1 forces reg_wr, mem_rd, mem_wr, is_csr, ecall, mret and done to 0.
- Simultaneous redirect_en with error/done: redirect wins.

Test Plan:
- Reset: rst=1 for one edge -> pc=0x80000000; release rst -> error=0 with a legal instr.
- addi x1,x0,5 (0x00500093), src1=0 -> rd=1, imm=5, result=5, reg_wr=1; next edge pc=0x80000004.
- addw x3,x1,x2 (0x002081bb), src1=0x7fffffff, src2=1 -> result=0xffffffff80000000, reg_wr=1.
- beq x1,x2,+8 (0x00208463): src1==src2 -> pc advances by 8; src1≠src2 -> pc+4, reg_wr=0.
- jalr x1,4(x2) (0x004100e7), src1=0x80001003 -> next pc=0x80001006, result=pc+4.
- Error/done/redirect:
  - instr 0x00000000 -> error=1, reg_wr=0, pc holds.
  - ebreak 0x00100073 -> done=1, pc holds.
  - redirect_en=1, redirect_pc=0x80000100 -> pc=0x80000100 next edge.
